// File: rtl/axi4l_reg_slave.sv
// axi4l_reg_slave: AXI4-Lite slave that terminates the bus in a bank of N_REGS
// memory-mapped registers. Independent write (AW/W/B) and read (AR/R) channels,
// byte strobes, OKAY/SLVERR responses, and read-only slots sourced from hw_rd_i.
// DATA_WIDTH must be 32 or 64; N_REGS must be at least 2.
module axi4l_reg_slave #(
    parameter int unsigned       DATA_WIDTH = 32,
    parameter int unsigned       ADDR_WIDTH = 32,
    parameter int unsigned       N_REGS     = 16,
    parameter logic [N_REGS-1:0] RO_MASK    = '0
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic [2:0]                   AWPROT,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    // write data channel
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [DATA_WIDTH/8-1:0]      WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    // write response channel
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic [2:0]                   ARPROT,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    // read data channel
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    // register-bank side
    input  logic [N_REGS*DATA_WIDTH-1:0] hw_rd_i,
    output logic [N_REGS*DATA_WIDTH-1:0] reg_q_o,
    output logic [N_REGS-1:0]            reg_wr_o
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned BYTE_BITS = $clog2(STRB_W);
    localparam int unsigned IDX_BITS  = $clog2(N_REGS);
    // One past the last mapped byte; one bit wider than the address so the
    // comparison cannot wrap for any ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] MAP_LIMIT = (ADDR_WIDTH + 1)'(N_REGS * STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    typedef logic [IDX_BITS-1:0]   idx_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    // ------------------------------------------------------------------
    // Address decode helpers
    // ------------------------------------------------------------------
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < MAP_LIMIT);
    endfunction

    // Word index; the byte-offset bits below it are ignored.
    function automatic idx_t addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[BYTE_BITS +: IDX_BITS];
    endfunction

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  aw_done_q, aw_done_d;   // AW beat captured, waiting for W
    logic                  w_done_q,  w_done_d;    // W beat captured, waiting for AW
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    word_t                 wdata_q,   wdata_d;
    logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic [N_REGS-1:0]     reg_wr_q,  reg_wr_d;
    word_t                 regs_q [N_REGS];
    word_t                 regs_d [N_REGS];

    logic                  aw_hs;
    logic                  w_hs;
    logic [ADDR_WIDTH-1:0] wr_addr;
    word_t                 wr_data;
    logic [STRB_W-1:0]     wr_strb;
    idx_t                  wr_idx;
    logic                  wr_ok;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    word_t                 rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;

    logic                  ar_hs;
    idx_t                  rd_idx;
    logic                  rd_in_range;

    // Protection attributes carry no meaning for this register bank.
    logic                  unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID  && wready_q;
    assign ar_hs = ARVALID && arready_q;

    // Whichever beat arrived earlier comes from its capture register; the
    // beat completing the pair this cycle comes straight off the bus.
    assign wr_addr = aw_done_q ? awaddr_q : AWADDR;
    assign wr_data = w_done_q  ? wdata_q  : WDATA;
    assign wr_strb = w_done_q  ? wstrb_q  : WSTRB;
    assign wr_idx  = addr_idx(wr_addr);
    assign wr_ok   = addr_in_range(wr_addr) && !RO_MASK[wr_idx];

    assign rd_idx      = addr_idx(ARADDR);
    assign rd_in_range = addr_in_range(ARADDR);

    // Write FSM: collect AW and W in any order, apply the write, then hold B.
    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        reg_wr_d  = '0;
        regs_d    = regs_q;

        case (w_state_q)
            W_IDLE: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    // Both halves present: commit and present the response.
                    w_state_d = W_RESP;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    if (wr_ok) begin
                        bresp_d          = RESP_OKAY;
                        reg_wr_d[wr_idx] = 1'b1;
                        for (int k = 0; k < STRB_W; k++) begin
                            if (wr_strb[k]) begin
                                regs_d[wr_idx][k*8 +: 8] = wr_data[k*8 +: 8];
                            end
                        end
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else begin
                    // At most one half has arrived; park it and stop
                    // accepting on that channel until its partner shows up.
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q  || w_hs;
                    awready_d = !(aw_done_q || aw_hs);
                    wready_d  = !(w_done_q  || w_hs);
                    if (aw_hs) begin
                        awaddr_d = AWADDR;
                    end
                    if (w_hs) begin
                        wdata_d = WDATA;
                        wstrb_d = WSTRB;
                    end
                end
            end

            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
        endcase
    end

    // Write-channel and register-bank state registers.
    // NOTE: the bank is built from flops rather than a RAM macro, so it takes
    // the asynchronous reset like any other state element.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            reg_wr_q  <= '0;
            regs_q    <= '{default: '0};
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            reg_wr_q  <= reg_wr_d;
            regs_q    <= regs_d;
        end
    end

    // Read FSM: accept one address, hold the data beat until RREADY.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    // regs_q is the pre-edge value, so a write landing on
                    // the same edge is not visible to this read.
                    if (!rd_in_range) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end else if (RO_MASK[rd_idx]) begin
                        rdata_d = hw_rd_i[rd_idx*DATA_WIDTH +: DATA_WIDTH];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = regs_q[rd_idx];
                        rresp_d = RESP_OKAY;
                    end
                end else begin
                    // Raises ARREADY on the first edge after reset release.
                    arready_d = 1'b1;
                end
            end

            R_DATA: begin
                if (RREADY) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
        endcase
    end

    // Read-channel state registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Flatten the bank for the consumers; read-only slots are never written
    // and therefore stay zero.
    for (genvar i = 0; i < N_REGS; i++) begin : g_reg_out
        assign reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign reg_wr_o = reg_wr_q;

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// tb_axi4l_reg_slave: directed scenarios plus randomized concurrent traffic.
// A transaction-level model of the register map runs on every falling edge and
// predicts every output of the slave; directed steps add literal expectations.
module tb_axi4l_reg_slave;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;
    localparam int MAP_BYTES = NR * DW / 8;
    localparam logic [NR-1:0] RO = 16'h0011;   // regs 0 and 4 are hardware-sourced

    logic              ACLK;
    logic              ARESETN;
    logic [AW-1:0]     AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    logic [DW-1:0]     WDATA;
    logic [DW/8-1:0]   WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [AW-1:0]     ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [NR*DW-1:0]  hw_rd_i;
    logic [NR*DW-1:0]  reg_q_o;
    logic [NR-1:0]     reg_wr_o;

    axi4l_reg_slave #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .N_REGS    (NR),
        .RO_MASK   (RO)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .AWADDR  (AWADDR),
        .AWPROT  (AWPROT),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARPROT  (ARPROT),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .hw_rd_i (hw_rd_i),
        .reg_q_o (reg_q_o),
        .reg_wr_o(reg_wr_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no handshake within the cycle budget", name);
    endtask

    // ------------------------------------------------------------------
    // Reference model: what the slave must show in the current cycle,
    // advanced once per cycle from the inputs that the next edge will see.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_regs [NR];
    logic          m_awrdy, m_wrdy, m_arrdy;
    logic          m_bvalid, m_rvalid;
    logic [1:0]    m_bresp, m_rresp;
    logic [DW-1:0] m_rdata;
    logic [NR-1:0] m_pulse;
    logic          m_aw_got, m_w_got;
    logic [AW-1:0] m_aw_addr;
    logic [DW-1:0] m_w_data;
    logic [3:0]    m_w_strb;

    always @(negedge ACLK) begin
        logic aw_hs, w_hs, ar_hs;
        int   idx;
        if (!ARESETN) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_awrdy = 0; m_wrdy = 0; m_arrdy = 0;
            m_bvalid = 0; m_bresp = 0;
            m_rvalid = 0; m_rresp = 0; m_rdata = 0;
            m_pulse = 0; m_aw_got = 0; m_w_got = 0;
        end

        check("AWREADY", AWREADY, m_awrdy);
        check("WREADY",  WREADY,  m_wrdy);
        check("ARREADY", ARREADY, m_arrdy);
        check("BVALID",  BVALID,  m_bvalid);
        check("RVALID",  RVALID,  m_rvalid);
        check("reg_wr_o", reg_wr_o, m_pulse);
        if (!ARESETN || m_bvalid) check("BRESP", BRESP, m_bresp);
        if (!ARESETN || m_rvalid) begin
            check("RDATA", RDATA, m_rdata);
            check("RRESP", RRESP, m_rresp);
        end
        for (int i = 0; i < NR; i++)
            check($sformatf("reg_q_o[%0d]", i), reg_q_o[i*DW +: DW], m_regs[i]);

        if (ARESETN) begin
            aw_hs = AWVALID && m_awrdy;
            w_hs  = WVALID  && m_wrdy;
            ar_hs = ARVALID && m_arrdy;

            // Read first: it must see the register map before any write
            // that lands on the same edge.
            if (ar_hs) begin
                m_rvalid = 1;
                if (ARADDR >= MAP_BYTES) begin
                    m_rdata = 0;
                    m_rresp = 2'b10;
                end else begin
                    idx     = int'(ARADDR / 4);
                    m_rdata = RO[idx] ? hw_rd_i[idx*DW +: DW] : m_regs[idx];
                    m_rresp = 2'b00;
                end
            end else if (m_rvalid && RREADY) begin
                m_rvalid = 0;
            end
            m_arrdy = !m_rvalid;

            m_pulse = '0;
            if (m_bvalid) begin
                if (BREADY) m_bvalid = 0;
            end else begin
                if (aw_hs) begin m_aw_got = 1; m_aw_addr = AWADDR; end
                if (w_hs)  begin m_w_got = 1; m_w_data = WDATA; m_w_strb = WSTRB; end
                if (m_aw_got && m_w_got) begin
                    m_aw_got = 0;
                    m_w_got  = 0;
                    m_bvalid = 1;
                    if (m_aw_addr < MAP_BYTES && !RO[int'(m_aw_addr / 4)]) begin
                        idx = int'(m_aw_addr / 4);
                        for (int k = 0; k < 4; k++)
                            if (m_w_strb[k]) m_regs[idx][k*8 +: 8] = m_w_data[k*8 +: 8];
                        m_pulse = NR'(1) << idx;
                        m_bresp = 2'b00;
                    end else begin
                        m_bresp = 2'b10;
                    end
                end
            end
            m_awrdy = !m_bvalid && !m_aw_got;
            m_wrdy  = !m_bvalid && !m_w_got;
        end
    end

    // ------------------------------------------------------------------
    // Bus drivers; each starts and ends 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic wr_addr_data(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w;
        int cyc = 0;
        while (!(aw_done && w_done)) begin
            AWVALID = !aw_done && (cyc >= aw_dly);
            AWADDR  = addr;
            AWPROT  = 3'($urandom);
            WVALID  = !w_done && (cyc >= w_dly);
            WDATA   = data;
            WSTRB   = strb;
            @(negedge ACLK);
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done  = 1;
            cyc++;
            if (cyc > 100 && !(aw_done && w_done)) begin
                timeout_fail("wr_addr_data");
                break;
            end
        end
        AWVALID = 0;
        WVALID  = 0;
    endtask

    task automatic wr_resp(input int b_dly, output logic [1:0] resp);
        bit done = 0;
        int cyc  = 0;
        resp = 2'b00;
        while (!done) begin
            BREADY = (cyc >= b_dly);
            @(negedge ACLK);
            if (BVALID && BREADY) begin done = 1; resp = BRESP; end
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > 100 && !done) begin
                timeout_fail("wr_resp");
                break;
            end
        end
        BREADY = 0;
    endtask

    task automatic rd_addr(input logic [AW-1:0] addr);
        bit done = 0;
        int cyc  = 0;
        while (!done) begin
            ARVALID = 1;
            ARADDR  = addr;
            ARPROT  = 3'($urandom);
            @(negedge ACLK);
            if (ARVALID && ARREADY) done = 1;
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > 100 && !done) begin
                timeout_fail("rd_addr");
                break;
            end
        end
        ARVALID = 0;
    endtask

    task automatic rd_data(input int r_dly, output logic [DW-1:0] data, output logic [1:0] resp);
        bit done = 0;
        int cyc  = 0;
        data = '0;
        resp = 2'b00;
        while (!done) begin
            RREADY = (cyc >= r_dly);
            @(negedge ACLK);
            if (RVALID && RREADY) begin done = 1; data = RDATA; resp = RRESP; end
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > 100 && !done) begin
                timeout_fail("rd_data");
                break;
            end
        end
        RREADY = 0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output logic [1:0] resp);
        wr_addr_data(addr, data, strb, aw_dly, w_dly);
        wr_resp(b_dly, resp);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int r_dly,
                           output logic [DW-1:0] data, output logic [1:0] resp);
        rd_addr(addr);
        rd_data(r_dly, data, resp);
    endtask

    // Overall time limit in case a handshake never resolves.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    bresp, rresp;
        logic [DW-1:0] rdata;
        logic [AW-1:0] a;

        ARESETN = 0;
        AWADDR = 0; AWPROT = 0; AWVALID = 0;
        WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
        for (int i = 0; i < NR; i++) hw_rd_i[i*DW +: DW] = $urandom;
        hw_rd_i[31:0] = 32'hCAFE_F00D;

        // Reset and release.
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", AWREADY, 0);
        check("rst_rdata",   RDATA,   0);
        ARESETN = 1;
        check("rel_awready_same_cycle", AWREADY, 0);
        @(posedge ACLK); #1;
        check("rel_awready", AWREADY, 1);
        check("rel_wready",  WREADY,  1);
        check("rel_arready", ARREADY, 1);

        // 1: AW+W together into reg 2.
        wr_addr_data(32'h8, 32'hA5A5_5A5A, 4'hF, 0, 0);
        check("t1_bvalid", BVALID, 1);
        check("t1_pulse",  reg_wr_o, 16'h0004);
        check("t1_reg2",   reg_q_o[2*DW +: DW], 32'hA5A5_5A5A);
        wr_resp(0, bresp);
        check("t1_bresp", bresp, 2'b00);
        check("t1_pulse_gone", reg_wr_o, 16'h0000);
        do_read(32'h8, 0, rdata, rresp);
        check("t1_rdata", rdata, 32'hA5A5_5A5A);
        check("t1_rresp", rresp, 2'b00);

        // 2: W three cycles ahead of AW, low half-word strobes.
        do_write(32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, bresp);
        wr_addr_data(32'h4, 32'h1234_5678, 4'b0011, 3, 0);
        wr_resp(0, bresp);
        check("t2_bresp", bresp, 2'b00);
        check("t2_reg1",  reg_q_o[1*DW +: DW], 32'hFFFF_5678);

        // 3: slow BREADY and slow RREADY.
        do_write(32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, 5, bresp);
        check("t3_bresp", bresp, 2'b00);
        do_read(32'h14, 5, rdata, rresp);
        check("t3_rdata", rdata, 32'hDEAD_BEEF);

        // 4: out of range and read-only targets.
        do_write(32'h40, 32'h1111_2222, 4'hF, 0, 0, 0, bresp);
        check("t4_oor_bresp", bresp, 2'b10);
        do_read(32'h40, 0, rdata, rresp);
        check("t4_oor_rresp", rresp, 2'b10);
        check("t4_oor_rdata", rdata, 32'h0);
        do_write(32'h0, 32'h5555_5555, 4'hF, 0, 0, 0, bresp);
        check("t4_ro_bresp", bresp, 2'b10);
        check("t4_ro_reg0",  reg_q_o[0 +: DW], 32'h0);
        do_read(32'h0, 0, rdata, rresp);
        check("t4_ro_rdata", rdata, 32'hCAFE_F00D);
        check("t4_ro_rresp", rresp, 2'b00);

        // 5: reset while both channels hold a response.
        wr_addr_data(32'h18, 32'h77, 4'hF, 0, 0);
        rd_addr(32'h8);
        check("t5_bvalid_pre", BVALID, 1);
        check("t5_rvalid_pre", RVALID, 1);
        ARESETN = 0;
        #1;
        check("t5_bvalid_async", BVALID, 0);
        check("t5_rvalid_async", RVALID, 0);
        check("t5_reg2_async",   reg_q_o[2*DW +: DW], 32'h0);
        check("t5_reg6_async",   reg_q_o[6*DW +: DW], 32'h0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1;
        check("t5_awready_rel", AWREADY, 0);
        @(posedge ACLK); #1;
        check("t5_awready_up", AWREADY, 1);
        check("t5_arready_up", ARREADY, 1);
        check("t5_no_bvalid",  BVALID, 0);
        do_write(32'h18, 32'h77, 4'hF, 0, 0, 0, bresp);
        check("t5_post_bresp", bresp, 2'b00);
        check("t5_post_reg6",  reg_q_o[6*DW +: DW], 32'h77);

        // 6: read and write of reg 3 on the same edge.
        do_write(32'hC, 32'h1, 4'hF, 0, 0, 0, bresp);
        fork
            wr_addr_data(32'hC, 32'h2, 4'hF, 0, 0);
            rd_addr(32'hC);
        join
        fork
            wr_resp(0, bresp);
            rd_data(0, rdata, rresp);
        join
        check("t6_old_value", rdata, 32'h1);
        do_read(32'hC, 0, rdata, rresp);
        check("t6_new_value", rdata, 32'h2);

        // Randomized concurrent traffic; the model checks every cycle.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) hw_rd_i[$urandom_range(0, NR-1)*DW +: DW] = $urandom;
            fork
                begin
                    logic [AW-1:0] wa;
                    logic [1:0]    wr;
                    wa = AW'($urandom_range(0, 32'h4F));
                    if ($urandom_range(0, 7) == 0) wa[28] = 1'b1;
                    if ($urandom_range(0, 3) != 0)
                        do_write(wa, $urandom, 4'($urandom), $urandom_range(0, 3),
                                 $urandom_range(0, 3), $urandom_range(0, 3), wr);
                end
                begin
                    logic [AW-1:0] ra;
                    logic [DW-1:0] rd;
                    logic [1:0]    rr;
                    ra = AW'($urandom_range(0, 32'h4F));
                    if ($urandom_range(0, 7) == 0) ra[30] = 1'b1;
                    if ($urandom_range(0, 3) != 0)
                        do_read(ra, $urandom_range(0, 3), rd, rr);
                end
            join
        end

        a = 32'h3C;
        do_write(a, 32'h0BAD_F00D, 4'b1000, 0, 0, 0, bresp);
        check("final_bresp", bresp, 2'b00);

        repeat (2) @(posedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
